// File: rtl/fp_pkg.sv
// Shared constants, state encoding and flag positions for the sequential FP divider.
// Defaults describe IEEE-754 single format.
package fp_pkg;

  localparam int DEF_EXP_W  = 8;
  localparam int DEF_MANT_W = 24;
  localparam int BIAS       = (1 << (DEF_EXP_W - 1)) - 1;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_DIV_ZERO  = 2;
  localparam int FLAG_OVERFLOW  = 1;
  localparam int FLAG_UNDERFLOW = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIV,
    ST_NORM,
    ST_DONE
  } state_t;

  function automatic int bias_of(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_exp_sub.sv
// Quotient exponent: exp_a - exp_b + bias as a signed value wide enough never to wrap.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module fp_exp_sub
  import fp_pkg::*;
#(
  parameter int EXP_W = DEF_EXP_W
) (
  input  logic [EXP_W-1:0]        exp_a,
  input  logic [EXP_W-1:0]        exp_b,
  output logic signed [EXP_W+1:0] exp_q
);

  localparam logic signed [EXP_W+1:0] BIAS_S = (EXP_W+2)'(bias_of(EXP_W));

  assign exp_q = $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS_S;

endmodule

// File: rtl/fp_div_seq.sv
// Sequential floating-point divider: restoring mantissa division, one quotient bit per clock.
// Latency: 1 edge for special operands, MANT_W+3 edges for finite nonzero operands.
// Backpressure: one op in flight; in_ready only when idle, result held until out_ready.
module fp_div_seq
  import fp_pkg::*;
#(
  parameter int EXP_W  = DEF_EXP_W,
  parameter int MANT_W = DEF_MANT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [EXP_W+MANT_W-1:0] a,
  input  logic [EXP_W+MANT_W-1:0] b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_W+MANT_W-1:0] res,
  output logic [3:0]              flags
);

  localparam int W  = EXP_W + MANT_W;
  localparam int FW = MANT_W - 1;
  localparam int RW = MANT_W + 1;
  localparam int QW = MANT_W + 2;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(MANT_W + 2);

  localparam logic [W-1:0] NAN_Q = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FW-1){1'b0}}};
  localparam logic signed [EW-1:0] E_ONE  = EW'(1);
  localparam logic signed [EW-1:0] E_ZERO = EW'(0);
  localparam logic signed [EW-1:0] E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MANT_W + 1);

  state_t                state;
  logic [RW-1:0]         rem_r;
  logic [MANT_W-1:0]     div_r;
  logic [QW-1:0]         quo_r;
  logic [CW-1:0]         cnt;
  logic signed [EW-1:0]  exp_r;
  logic                  sign_r;

  logic                  sa, sb;
  logic [EXP_W-1:0]      ea, eb;
  logic [FW-1:0]         fa, fb;
  logic                  a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, is_special;
  logic signed [EW-1:0]  exp_in;

  assign sa = a[W-1];
  assign sb = b[W-1];
  assign ea = a[W-2 -: EXP_W];
  assign eb = b[W-2 -: EXP_W];
  assign fa = a[FW-1:0];
  assign fb = b[FW-1:0];

  // Zero exponent means zero: denormal fractions are flushed.
  assign a_zero     = (ea == '0);
  assign b_zero     = (eb == '0);
  assign a_inf      = (&ea) && (fa == '0);
  assign b_inf      = (&eb) && (fb == '0);
  assign a_nan      = (&ea) && (fa != '0);
  assign b_nan      = (&eb) && (fb != '0);
  assign is_special = a_zero || b_zero || (&ea) || (&eb);

  fp_exp_sub #(.EXP_W(EXP_W)) u_exp_sub (
    .exp_a (ea),
    .exp_b (eb),
    .exp_q (exp_in)
  );

  // The first quotient bit is resolved on the accepting edge so that the
  // remaining MANT_W+1 bits plus one normalisation edge give MANT_W+3 total.
  logic [RW-1:0] r_init, d_init, r_first;
  logic          q_first;

  assign r_init  = {1'b0, 1'b1, fa};
  assign d_init  = {1'b0, 1'b1, fb};
  assign q_first = (r_init >= d_init);
  assign r_first = (q_first ? (r_init - d_init) : r_init) << 1;

  logic [W-1:0] sp_res;
  logic [3:0]   sp_flags;

  always_comb begin
    sp_res   = '0;
    sp_flags = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      sp_res                 = NAN_Q;
      sp_flags[FLAG_INVALID] = 1'b1;
    end else if (a_inf) begin
      sp_res = {sa ^ sb, {EXP_W{1'b1}}, {FW{1'b0}}};
    end else if (b_zero) begin
      sp_res                  = {sa ^ sb, {EXP_W{1'b1}}, {FW{1'b0}}};
      sp_flags[FLAG_DIV_ZERO] = 1'b1;
    end else begin
      sp_res = {sa ^ sb, {(W-1){1'b0}}};
    end
  end

  logic [RW-1:0] div_ext, rem_next;
  logic          q_bit;

  assign div_ext  = {1'b0, div_r};
  assign q_bit    = (rem_r >= div_ext);
  assign rem_next = (q_bit ? (rem_r - div_ext) : rem_r) << 1;

  // Normalise, round to nearest even, then range-check the final exponent.
  logic [FW-1:0]        frac_t, frac_out;
  logic [FW:0]          frac_sum;
  logic                 guard, sticky, rnd_up;
  logic signed [EW-1:0] e_norm, e_rnd;
  logic [W-1:0]         fin_res;
  logic [3:0]           fin_flags;

  always_comb begin
    if (quo_r[QW-1]) begin
      frac_t = quo_r[QW-2:2];
      guard  = quo_r[1];
      e_norm = exp_r;
    end else begin
      frac_t = quo_r[QW-3:1];
      guard  = quo_r[0];
      e_norm = exp_r - E_ONE;
    end
    sticky   = (quo_r[QW-1] && quo_r[0]) || (rem_r != '0);
    rnd_up   = guard && (sticky || frac_t[0]);
    frac_sum = {1'b0, frac_t} + {{FW{1'b0}}, rnd_up};
    frac_out = frac_sum[FW-1:0];
    e_rnd    = frac_sum[FW] ? (e_norm + E_ONE) : e_norm;
    fin_res   = '0;
    fin_flags = '0;
    if (e_rnd >= E_MAX) begin
      fin_res                  = {sign_r, {EXP_W{1'b1}}, {FW{1'b0}}};
      fin_flags[FLAG_OVERFLOW] = 1'b1;
    end else if (e_rnd <= E_ZERO) begin
      fin_res                   = {sign_r, {(W-1){1'b0}}};
      fin_flags[FLAG_UNDERFLOW] = 1'b1;
    end else begin
      fin_res = {sign_r, e_rnd[EXP_W-1:0], frac_out};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      res       <= '0;
      flags     <= '0;
      rem_r     <= '0;
      div_r     <= '0;
      quo_r     <= '0;
      cnt       <= '0;
      exp_r     <= '0;
      sign_r    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (is_special) begin
              res       <= sp_res;
              flags     <= sp_flags;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              flags  <= '0;
              rem_r  <= r_first;
              div_r  <= {1'b1, fb};
              quo_r  <= {{(QW-1){1'b0}}, q_first};
              cnt    <= CW'(1);
              exp_r  <= exp_in;
              sign_r <= sa ^ sb;
              state  <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          rem_r <= rem_next;
          quo_r <= {quo_r[QW-2:0], q_bit};
          cnt   <= cnt + 1'b1;
          if (cnt == CNT_LAST) state <= ST_NORM;
        end
        ST_NORM: begin
          res       <= fin_res;
          flags     <= fin_flags;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
// Bench for fp_div_seq: directed cases plus random operands against an exact-arithmetic reference.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] res;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  fp_div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  always #5 clk = ~clk;

  // Reference: exact integer quotient with many extra bits, then IEEE round-to-nearest-even.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    int ex, ey, e;
    logic [22:0] fx, fy;
    logic s;
    longint unsigned mx, my, n, q, rm, mant;
    bit g, st, xz, yz, xi, yi, xn, yn;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    fx = x[22:0];
    fy = y[22:0];
    s  = x[31] ^ y[31];
    xz = (ex == 0);
    yz = (ey == 0);
    xi = (ex == 255) && (fx == 0);
    yi = (ey == 255) && (fy == 0);
    xn = (ex == 255) && (fx != 0);
    yn = (ey == 255) && (fy != 0);
    f = 4'b0000;
    r = 32'h0;
    lat = 1;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      r = 32'h7FC00000;
      f = 4'b1000;
    end else if (xi) begin
      r = {s, 8'hFF, 23'h0};
    end else if (yz) begin
      r = {s, 8'hFF, 23'h0};
      f = 4'b0100;
    end else if (xz || yi) begin
      r = {s, 31'h0};
    end else begin
      lat = 27;
      mx = {40'd0, 1'b1, fx};
      my = {40'd0, 1'b1, fy};
      n  = mx << 26;
      q  = n / my;
      rm = n % my;
      e  = ex - ey + 127;
      if (q >= (64'd1 << 26)) begin
        mant = q >> 3;
        g    = q[2];
        st   = (q[1:0] != 0) || (rm != 0);
      end else begin
        mant = q >> 2;
        g    = q[1];
        st   = q[0] || (rm != 0);
        e    = e - 1;
      end
      if (g && (st || mant[0])) mant = mant + 1;
      if (mant == (64'd1 << 24)) begin
        mant = 64'd1 << 23;
        e    = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0010;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0001;
      end else begin
        r = {s, e[7:0], mant[22:0]};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    int k;
    v = $urandom;
    k = $urandom_range(0, 19);
    case (k)
      0:       v[30:23] = 8'h00;
      1:       v[30:0]  = {8'hFF, 23'h0};
      2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
      3:       begin v[30:23] = 8'(  $urandom_range(1, 20)); end
      4:       begin v[30:23] = 8'($urandom_range(235, 254)); end
      5:       begin v[30:23] = 8'($urandom_range(100, 154)); v[22:0] = 23'h0; end
      6:       begin v[30:23] = 8'($urandom_range(100, 154)); v[15:0] = 16'h0; end
      default: v[30:23] = 8'($urandom_range(100, 154));
    endcase
    return v;
  endfunction

  // Drives one operation, measures edges from accept to out_valid, then hands the result off.
  task automatic do_op(input logic [31:0] opa, input logic [31:0] opb,
                       output logic [31:0] r, output logic [3:0] f, output int lat, output bit to);
    @(negedge clk);
    a = opa;
    b = opb;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 60) begin
      @(posedge clk);
      #1 lat++;
    end
    to = (out_valid !== 1'b1);
    r = res;
    f = flags;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (res !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 00000000", res); end
    n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL reset_flags got %b want 0000", flags); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input string name, input logic [31:0] ta [], input logic [31:0] tb [],
                           input logic [31:0] tr [], input logic [3:0] tf [], input int tl []);
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    bit to;
    for (int i = 0; i < ta.size(); i++) begin
      do_op(ta[i], tb[i], r, f, lat, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL %s[%0d] timeout out_valid got 0 want 1", name, i); end
      n_checks++; if (r !== tr[i]) begin n_fail++; $display("FAIL %s[%0d] res got %h want %h", name, i, r, tr[i]); end
      n_checks++; if (f !== tf[i]) begin n_fail++; $display("FAIL %s[%0d] flags got %b want %b", name, i, f, tf[i]); end
      n_checks++; if (lat !== tl[i]) begin n_fail++; $display("FAIL %s[%0d] latency got %0d want %0d", name, i, lat, tl[i]); end
    end
  endtask

  task automatic test_finite();
    logic [31:0] ta [] = '{32'h40C00000, 32'hC0C00000, 32'h3F800000};
    logic [31:0] tb [] = '{32'h40000000, 32'h40000000, 32'h40400000};
    logic [31:0] tr [] = '{32'h40400000, 32'hC0400000, 32'h3EAAAAAB};
    logic [3:0]  tf [] = '{4'h0, 4'h0, 4'h0};
    int          tl [] = '{27, 27, 27};
    run_table("finite", ta, tb, tr, tf, tl);
  endtask

  task automatic test_special();
    logic [31:0] ta [] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000,
                           32'h7FC12345, 32'h00000000, 32'h40A00000, 32'hFF800000};
    logic [31:0] tb [] = '{32'h00000000, 32'h00000000, 32'h40000000, 32'h7F800000,
                           32'h3F800000, 32'h40A00000, 32'hFF800000, 32'h00000000};
    logic [31:0] tr [] = '{32'h7F800000, 32'h7FC00000, 32'h7F800000, 32'h7FC00000,
                           32'h7FC00000, 32'h00000000, 32'h80000000, 32'hFF800000};
    logic [3:0]  tf [] = '{4'b0100, 4'b1000, 4'b0000, 4'b1000,
                           4'b1000, 4'b0000, 4'b0000, 4'b0000};
    int          tl [] = '{1, 1, 1, 1, 1, 1, 1, 1};
    run_table("special", ta, tb, tr, tf, tl);
  endtask

  task automatic test_range();
    logic [31:0] ta [] = '{32'h7F000000, 32'h00800000, 32'h80800000, 32'h7F7FFFFF};
    logic [31:0] tb [] = '{32'h3E800000, 32'h40000000, 32'h40000000, 32'h3F800000};
    logic [31:0] tr [] = '{32'h7F800000, 32'h00000000, 32'h80000000, 32'h7F7FFFFF};
    logic [3:0]  tf [] = '{4'b0010, 4'b0001, 4'b0001, 4'b0000};
    int          tl [] = '{27, 27, 27, 27};
    run_table("range", ta, tb, tr, tf, tl);
  endtask

  task automatic test_random();
    logic [31:0] x, y, r, er;
    logic [3:0] f, ef;
    int lat, el;
    bit to;
    for (int i = 0; i < 300; i++) begin
      x = rand_op();
      y = rand_op();
      model(x, y, er, ef, el);
      do_op(x, y, r, f, lat, to);
      n_checks++; if (to) begin n_fail++; $display("FAIL rand[%0d] timeout a=%h b=%h", i, x, y); end
      n_checks++; if (r !== er) begin n_fail++; $display("FAIL rand[%0d] res a=%h b=%h got %h want %h", i, x, y, r, er); end
      n_checks++; if (f !== ef) begin n_fail++; $display("FAIL rand[%0d] flags a=%h b=%h got %b want %b", i, x, y, f, ef); end
      n_checks++; if (lat !== el) begin n_fail++; $display("FAIL rand[%0d] latency a=%h b=%h got %0d want %0d", i, x, y, lat, el); end
    end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    n = 1;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_first timeout out_valid got %b want 1", out_valid); end
    @(negedge clk);
    a = 32'h3F800000;
    b = 32'h40400000;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++; if (res !== 32'h40400000) begin n_fail++; $display("FAIL bp_hold[%0d] res got %h want 40400000", i, res); end
      n_checks++; if (flags !== 4'h0) begin n_fail++; $display("FAIL bp_hold[%0d] flags got %b want 0000", i, flags); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_hold[%0d] out_valid got %b want 1", i, out_valid); end
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold[%0d] in_ready got %b want 0", i, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_handoff out_valid got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_handoff in_ready got %b want 1", in_ready); end
    @(posedge clk);
    #1 in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_second_accept in_ready got %b want 0", in_ready); end
    n = 1;
    while (out_valid !== 1'b1 && n < 60) begin
      @(posedge clk);
      #1 n++;
    end
    n_checks++; if (n !== 27) begin n_fail++; $display("FAIL bp_second latency got %0d want 27", n); end
    n_checks++; if (res !== 32'h3EAAAAAB) begin n_fail++; $display("FAIL bp_second res got %h want 3EAAAAAB", res); end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    logic [3:0] f;
    int lat;
    bit to;
    @(negedge clk);
    a = 32'h40C00000;
    b = 32'h40000000;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst in_ready got %b want 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst out_valid got %b want 0", out_valid); end
    do_op(32'h40C00000, 32'h40000000, r, f, lat, to);
    n_checks++; if (to) begin n_fail++; $display("FAIL midrst_after timeout out_valid got 0 want 1"); end
    n_checks++; if (r !== 32'h40400000) begin n_fail++; $display("FAIL midrst_after res got %h want 40400000", r); end
    n_checks++; if (lat !== 27) begin n_fail++; $display("FAIL midrst_after latency got %0d want 27", lat); end
  endtask

  initial begin
    test_reset();
    test_finite();
    test_special();
    test_range();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
